// File: rtl/l1_platform_pkg.sv
// Shared defaults and the SPI master state encoding for l1_platform.
package l1_platform_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_HALF_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } master_state_e;

endpackage

// File: rtl/l1_platform_spi_master.sv
// SPI mode-0 master, MSB first. One exchange per im_work_en request.
// Ports: clk, rst (async, high); work_en request; tx_data byte to send;
//        rx_data byte received; work_end completion level;
//        sclk/cs_n/mosi driven to the slave, miso from the slave.
module spi_master
  import l1_platform_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned HALF_DIV = DEF_HALF_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              work_en,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              work_end,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned CNT_W = $clog2(HALF_DIV + 1);
  localparam int unsigned TGL_W = $clog2(2 * DATA_W + 1);

  master_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TGL_W-1:0]  tgl_q, tgl_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              end_q, end_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next-state and datapath for one exchange.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgl_d   = tgl_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    end_d   = end_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (work_en) begin
          state_d = SETUP;
          tx_d    = tx_data;
          rx_d    = '0;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          tgl_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(HALF_DIV - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(HALF_DIV - 1)) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          tgl_d  = tgl_q + TGL_W'(1);
          // Rising toggle samples, falling toggle advances mosi.
          if (!sclk_q) rx_d = {rx_q[DATA_W-2:0], miso};
          else         tx_d = {tx_q[DATA_W-2:0], 1'b0};
          if (tgl_q == TGL_W'(2 * DATA_W - 1)) state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        // Counts one extra edge so the close-out lands on its own edge.
        if (cnt_q == CNT_W'(HALF_DIV)) begin
          state_d = DONE;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          data_d  = rx_q;
          end_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (!work_en) begin
          end_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgl_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      end_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgl_q   <= tgl_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      end_q   <= end_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
    end
  end

  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign mosi     = tx_q[DATA_W-1];
  assign work_end = end_q;
  assign rx_data  = data_q;

endmodule

// File: rtl/l1_platform_spi_slave.sv
// SPI mode-0 slave, MSB first, oversampling sclk/cs_n on clk.
// Ports: clk, rst (async, high); work_en request level (clears work_end);
//        tx_data byte to send; rx_data byte received; work_end completion;
//        sclk/cs_n/mosi from the master, miso to the master.
module spi_slave
  import l1_platform_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              work_en,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              work_end,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  logic              sclk_prev_q, sclk_prev_d;
  logic              cs_prev_q, cs_prev_d;
  logic              end_q, end_d;
  logic [BIT_W-1:0]  bits_q, bits_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_rise = sclk & ~sclk_prev_q;
  assign sclk_fall = ~sclk & sclk_prev_q;
  assign cs_fall   = ~cs_n & cs_prev_q;
  assign cs_rise   = cs_n & ~cs_prev_q;

  // Edge-driven shift/capture; completion only on a full byte.
  always_comb begin
    sclk_prev_d = sclk;
    cs_prev_d   = cs_n;
    end_d       = end_q;
    bits_d      = bits_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    data_d      = data_q;
    if (end_q && !work_en) end_d = 1'b0;
    if (cs_fall) begin
      tx_d   = tx_data;
      rx_d   = '0;
      bits_d = '0;
    end else if (!cs_n) begin
      if (sclk_rise) begin
        rx_d   = {rx_q[DATA_W-2:0], mosi};
        bits_d = bits_q + BIT_W'(1);
      end
      if (sclk_fall) tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end
    if (cs_rise) begin
      bits_d = '0;
      if (bits_q == BIT_W'(DATA_W)) begin
        data_d = rx_q;
        end_d  = 1'b1;
      end else begin
        rx_d = '0;
      end
    end
  end

  // State register; cs_n history resets high so reset is not seen as a select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      end_q       <= 1'b0;
      bits_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      data_q      <= '0;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      end_q       <= end_d;
      bits_q      <= bits_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      data_q      <= data_d;
    end
  end

  assign miso     = tx_q[DATA_W-1] & ~cs_n;
  assign work_end = end_q;
  assign rx_data  = data_q;

endmodule

// File: rtl/l1_platform.sv
// Loopback platform: an SPI master and SPI slave exchanging one byte each.
// Ports: clk, rst (async, high); im_work_en request; im_data_bus_master/slave
//        bytes to send; om_data_bus_master/slave bytes received;
//        om_work_end_master/slave completion levels.
module l1_platform
  import l1_platform_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned HALF_DIV = DEF_HALF_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_work_en,
  output logic              om_work_end_master,
  output logic              om_work_end_slave,
  input  logic [DATA_W-1:0] im_data_bus_master,
  input  logic [DATA_W-1:0] im_data_bus_slave,
  output logic [DATA_W-1:0] om_data_bus_master,
  output logic [DATA_W-1:0] om_data_bus_slave
);

  logic sclk, cs_n, mosi, miso;

  spi_master #(.DATA_W(DATA_W), .HALF_DIV(HALF_DIV)) u_master (
    .clk      (clk),
    .rst      (rst),
    .work_en  (im_work_en),
    .tx_data  (im_data_bus_master),
    .rx_data  (om_data_bus_master),
    .work_end (om_work_end_master),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso)
  );

  spi_slave #(.DATA_W(DATA_W)) u_slave (
    .clk      (clk),
    .rst      (rst),
    .work_en  (im_work_en),
    .tx_data  (im_data_bus_slave),
    .rx_data  (om_data_bus_slave),
    .work_end (om_work_end_slave),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso)
  );

endmodule

// File: tb/tb_l1_platform.sv
// Scoreboard bench for l1_platform: stimulus pushes swapped bytes and start
// cycles; a monitor pops them on each end-flag rise.
module tb_l1_platform;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned HALF_DIV = 4;
  localparam int          LAT      = 18 * HALF_DIV + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic [DATA_W-1:0] dm  = '0;
  logic [DATA_W-1:0] ds  = '0;
  logic              end_m, end_s;
  logic [DATA_W-1:0] om_m, om_s;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [DATA_W-1:0] exp_m_q[$];
  logic [DATA_W-1:0] exp_s_q[$];
  int                start_q[$];
  logic [DATA_W-1:0] model_m = '0;
  logic [DATA_W-1:0] model_s = '0;
  logic              prev_em = 1'b0;
  logic              prev_es = 1'b0;
  int                last_m_rise = 0;
  int                st;

  l1_platform #(.DATA_W(DATA_W), .HALF_DIV(HALF_DIV)) u_dut (
    .clk                (clk),
    .rst                (rst),
    .im_work_en         (en),
    .om_work_end_master (end_m),
    .om_work_end_slave  (end_s),
    .im_data_bus_master (dm),
    .im_data_bus_slave  (ds),
    .om_data_bus_master (om_m),
    .om_data_bus_slave  (om_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops expectations on each end-flag rise; buses must hold otherwise.
  always @(negedge clk) begin
    if (rst) begin
      model_m = '0;
      model_s = '0;
      prev_em = 1'b0;
      prev_es = 1'b0;
    end else begin
      if (end_m && !prev_em) begin
        check("master_end_expected", 32'(exp_m_q.size() > 0), 1);
        if (exp_m_q.size() > 0) begin
          model_m = exp_m_q.pop_front();
          st      = start_q.pop_front();
          check("master_latency", 32'(cyc - st), 32'(LAT));
        end
        last_m_rise = cyc;
      end
      if (end_s && !prev_es) begin
        check("slave_end_expected", 32'(exp_s_q.size() > 0), 1);
        if (exp_s_q.size() > 0) model_s = exp_s_q.pop_front();
        check("slave_end_delay", 32'((cyc - last_m_rise) inside {[0:2]}), 1);
      end
      check("master_bus", 32'(om_m), 32'(model_m));
      check("slave_bus", 32'(om_s), 32'(model_s));
      prev_em = end_m;
      prev_es = end_s;
    end
  end

  task automatic start_xfer(input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] s,
                            input bit expect_done);
    @(negedge clk);
    dm = m;
    ds = s;
    en = 1'b1;
    if (expect_done) begin
      exp_m_q.push_back(s);
      exp_s_q.push_back(m);
      start_q.push_back(cyc + 1);
    end
  endtask

  task automatic wait_both();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (end_m && end_s) begin
        ok = 1'b1;
        break;
      end
    end
    check("end_flags_timeout", 32'(ok), 1);
  endtask

  task automatic drop_and_check();
    en = 1'b0;
    @(negedge clk);
    check("end_m_clear", 32'(end_m), 0);
    check("end_s_clear", 32'(end_s), 0);
  endtask

  task automatic normal(input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] s);
    start_xfer(m, s, 1'b1);
    wait_both();
    drop_and_check();
    repeat (9) @(negedge clk);
  endtask

  initial begin
    int hm;
    int hs;
    logic [DATA_W-1:0] rm, rs;

    // Reset state
    @(negedge clk);
    check("rst_om_m", 32'(om_m), 0);
    check("rst_om_s", 32'(om_s), 0);
    check("rst_end_m", 32'(end_m), 0);
    check("rst_end_s", 32'(end_s), 0);
    check("rst_cs_n", 32'(u_dut.cs_n), 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    normal(8'h10, 8'h54);
    normal(8'h44, 8'h23);
    normal(8'h21, 8'h75);
    normal(8'h34, 8'h86);
    normal(8'h77, 8'h23);
    normal(8'h88, 8'h56);
    normal(8'h32, 8'h12);
    normal(8'h16, 8'h79);
    normal(8'h80, 8'h01);

    // Request held high long after completion
    rm = DATA_W'($urandom);
    rs = DATA_W'($urandom);
    start_xfer(rm, rs, 1'b1);
    wait_both();
    repeat (200) begin
      @(negedge clk);
      check("hold_end_m", 32'(end_m), 1);
      check("hold_end_s", 32'(end_s), 1);
      check("hold_cs_n", 32'(u_dut.cs_n), 1);
    end
    drop_and_check();
    repeat (9) @(negedge clk);

    // Reset mid-transfer aborts with no flag and no bus update
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    start_xfer(8'hA5, 8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    check("abort_om_m", 32'(om_m), 0);
    check("abort_om_s", 32'(om_s), 0);
    check("abort_cs_n", 32'(u_dut.cs_n), 1);
    @(negedge clk);
    rst = 1'b0;
    hm = 0;
    hs = 0;
    repeat (100) begin
      @(negedge clk);
      hm += int'(end_m);
      hs += int'(end_s);
    end
    check("abort_no_end_m", 32'(hm), 0);
    check("abort_no_end_s", 32'(hs), 0);
    normal(8'hA5, 8'h3C);

    // Request dropped mid-transfer: one-cycle end pulses
    start_xfer(8'hFF, 8'h00, 1'b1);
    repeat (20) @(negedge clk);
    en = 1'b0;
    hm = 0;
    hs = 0;
    repeat (120) begin
      @(negedge clk);
      hm += int'(end_m);
      hs += int'(end_s);
    end
    check("pulse_end_m", 32'(hm), 1);
    check("pulse_end_s", 32'(hs), 1);
    repeat (5) @(negedge clk);

    // Random pairs
    for (int i = 0; i < 8; i++) begin
      rm = DATA_W'($urandom);
      rs = DATA_W'($urandom);
      normal(rm, rs);
    end

    repeat (5) @(negedge clk);
    check("pending_master", 32'(exp_m_q.size()), 0);
    check("pending_slave", 32'(exp_s_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_fail);
    $fatal(1);
  end

endmodule
